// File: rtl/snake_defs.sv
// Shared snake definitions: direction codes, axis helper and game state encodings.
package snake_defs;
    localparam int DIR_W = 2;
    typedef logic [DIR_W-1:0] dir_t;

    localparam dir_t DIR_X0 = 2'd0;
    localparam dir_t DIR_X1 = 2'd1;
    localparam dir_t DIR_Y0 = 2'd2;
    localparam dir_t DIR_Y1 = 2'd3;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_RUN  = 2'd1,
        GS_OVER = 2'd2
    } game_state_t;

    function automatic logic dir_axis(input dir_t d);
        return d[1];
    endfunction
endpackage

// File: rtl/move_scheduler_key_debounce.sv
// One raw active-low key: 2-flop synchronizer, stable-low debounce and a single press pulse per press.
module key_debounce #(
    parameter int DEB_CYC = 1_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key,
    output logic press
);
    localparam int CW = $clog2(DEB_CYC + 1);

    logic          key_s1;
    logic          key_s2;
    logic          armed;
    logic [CW-1:0] deb_cnt;

    // Down-counter reloads while the key reads high; reaching zero while low fires once and disarms.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_s1  <= 1'b0;
            key_s2  <= 1'b0;
            armed   <= 1'b0;
            deb_cnt <= '0;
            press   <= 1'b0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            press  <= 1'b0;
            if (key_s2) begin
                armed   <= 1'b1;
                deb_cnt <= CW'(DEB_CYC);
            end else if (armed) begin
                if (deb_cnt == '0) begin
                    press <= 1'b1;
                    armed <= 1'b0;
                end else begin
                    deb_cnt <= deb_cnt - CW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/move_scheduler.sv
// Snake heading scheduler: debounced keys feed a 2-deep turn queue popped once per movement step.
module move_scheduler
    import snake_defs::*;
#(
    parameter int STEP_CYC = 10_000_000,
    parameter int DEB_CYC  = 1_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key,
    input  logic       pengzhuang,
    input  logic       pengzhuang2,
    output logic [2:0] direction,
    output logic       step,
    output logic [1:0] game_state,
    output logic [1:0] q_level
);
    localparam int TW = $clog2(STEP_CYC);

    logic [3:0]    press;
    logic          press_any;
    dir_t          press_dir;
    game_state_t   state;
    dir_t          dir_q;
    dir_t          q_head;
    dir_t          q_tail;
    logic [1:0]    q_cnt;
    logic [TW-1:0] timer;

    logic          tc;
    logic          pop;
    dir_t          dir_pp;
    dir_t          head_pp;
    logic [1:0]    cnt_pp;
    dir_t          ref_dir;
    logic          accept;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_debounce #(.DEB_CYC(DEB_CYC)) u_deb (
            .sys_clk   (sys_clk),
            .sys_rst_n (sys_rst_n),
            .key       (key[gi]),
            .press     (press[gi])
        );
    end

    assign press_any = |press;

    always_comb begin
        casez (press)
            4'b???1: press_dir = DIR_X0;
            4'b??10: press_dir = DIR_X1;
            4'b?100: press_dir = DIR_Y0;
            default: press_dir = DIR_Y1;
        endcase
    end

    // Pop happens before validation, so a press is checked against the post-pop plan.
    always_comb begin
        tc      = (timer == TW'(STEP_CYC - 1));
        pop     = tc && (q_cnt != 2'd0);
        dir_pp  = pop ? q_head : dir_q;
        head_pp = pop ? q_tail : q_head;
        cnt_pp  = pop ? q_cnt - 2'd1 : q_cnt;
        ref_dir = (cnt_pp != 2'd0) ? q_tail : dir_pp;
        accept  = press_any && (dir_axis(press_dir) != dir_axis(ref_dir)) && (cnt_pp != 2'd2);
    end

    // state   | meaning
    // GS_IDLE | waiting for any press to start, heading 0, timer parked
    // GS_RUN  | stepping, queueing turns, watching collision flags
    // GS_OVER | frozen after collision, any press returns to idle
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state  <= GS_IDLE;
            dir_q  <= DIR_X0;
            q_head <= DIR_X0;
            q_tail <= DIR_X0;
            q_cnt  <= 2'd0;
            timer  <= '0;
            step   <= 1'b0;
        end else begin
            step <= 1'b0;
            unique case (state)
                GS_IDLE: begin
                    timer <= '0;
                    if (press_any) state <= GS_RUN;
                end
                GS_RUN: begin
                    if (pengzhuang || pengzhuang2) begin
                        state <= GS_OVER;
                        dir_q <= DIR_X0;
                        q_cnt <= 2'd0;
                        timer <= '0;
                    end else begin
                        timer <= tc ? '0 : timer + TW'(1);
                        step  <= tc;
                        dir_q <= dir_pp;
                        if (accept) begin
                            q_cnt  <= cnt_pp + 2'd1;
                            q_tail <= press_dir;
                            q_head <= (cnt_pp == 2'd0) ? press_dir : head_pp;
                        end else begin
                            q_cnt  <= cnt_pp;
                            q_head <= head_pp;
                        end
                    end
                end
                GS_OVER: begin
                    if (press_any) state <= GS_IDLE;
                end
                default: state <= GS_IDLE;
            endcase
        end
    end

    assign direction  = {1'b0, dir_q};
    assign game_state = state;
    assign q_level    = q_cnt;
endmodule

// File: doc/move_scheduler.md
# move_scheduler

Schedules the snake's heading. It debounces the four direction keys and queues up to two validated turn requests. It applies at most one turn per movement step on a fixed step timer, and runs a small IDLE/RUN/OVER game state machine driven by the collision inputs. It sits between the raw board keys and the movement/drawing logic, replacing direct key-to-direction writes.

## Interface
- STEP_CYC, 10_000_000: clock cycles per movement step (200 ms at 50 MHz).
- DEB_CYC, 1_000_000: cycles a key must be stably low to count as a press (20 ms).
- sys_clk  in  1  50 MHz system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- key  in  4  raw buttons, active-low; key[i] requests direction code i.
- pengzhuang  in  1  collision flag 1, active-high level.
- pengzhuang2  in  1  collision flag 2, active-high level.
- direction  out  3  current heading code, 0..3.
- step  out  1  one-cycle pulse per movement step, RUN only.
- game_state  out  2  0=IDLE, 1=RUN, 2=OVER.
- q_level  out  2  pending turn count, 0..2.

## Operation
- **Direction codes:** 0 and 1 form the X axis; 2 and 3 form the Y axis. A turn is legal only onto the other axis. Same-direction and reversal requests are rejected.
- **Key input:** each key passes through a 2-flop synchronizer and then a debounce counter. A press pulse fires once per debounced falling edge. Release needs no debounce beyond re-arming once the key is sampled high.
- **Multiple presses in one cycle:** the lowest index wins and the others are dropped.
- **IDLE** (reset state): direction=0, timer held at 0, queue empty. Any press moves to RUN; that press is consumed and not enqueued.
- **RUN, step timer:** counts 0..STEP_CYC-1. At terminal count it wraps, pulses step, and pops the queue head into direction (direction is unchanged if the queue is empty).
- **RUN, enqueue:** a press is validated against the last planned heading. That is the queue tail if q_level>0, else direction. It is enqueued if legal and q_level<2; otherwise it is silently dropped.
- **RUN, collision:** pengzhuang|pengzhuang2 high moves to OVER. In the same edge: direction<=0, queue flushed, timer<=0.
- **OVER:** step never fires and presses are not enqueued. Any press moves to IDLE and is consumed.
- **Simultaneous pop and enqueue:** the pop is applied first. The press is validated against the post-pop tail, or against the newly popped direction if the queue becomes empty. A full queue with a pop therefore accepts the press.
- **Simultaneous collision and terminal count:** collision wins; no step pulse and no pop.
- **Reset mid-operation:** all state is cleared immediately (asynchronous), including debounce counters.

## Timing
- **Reset values:** direction=0, step=0, game_state=0, q_level=0; timer, queue and debounce state cleared.
- **Press latency:** raw key held low at cycle t gives the internal press pulse at cycle t+DEB_CYC+2. q_level or game_state reflects it one cycle later.
- **Step:** step and the new direction become visible on the same output cycle, registered. The first step comes STEP_CYC cycles after entering RUN.
- **Collision:** sampled every cycle in RUN. game_state=2 one cycle after the flag is high.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- **Shared definitions file (snake_defs):** direction codes, an axis helper (code[1]), game_state encodings, and a 2-bit direction width constant.
- **Direction output:** zero-extended to 3 bits so existing direction consumers connect unchanged.
- **Sub-module key_debounce:** synchronizer, DEB_CYC counter and press pulse. Instantiated four times via generate.
- **Top level:** the queue (2 entries, head/tail registers), step timer and FSM.
- **Timer width:** $clog2(STEP_CYC); the counter wraps exactly at STEP_CYC-1 with no off-by-one.

## Test plan
Common setup: STEP_CYC=16, DEB_CYC=4.
- **Reset/start:** release reset, pulse key[2] low for 10 cycles -> game_state goes 0->1; q_level stays 0; direction=0; first step arrives 16 cycles after RUN entry.
- **Turn queueing:** in RUN with direction=0, press key[2] then key[1] before a step -> q_level=2. Next step gives direction=2, q_level=1. Following step gives direction=1, q_level=0.
- **Rejection:** direction=0, press key[1], then key[0] -> q_level stays 0. With queue tail=2, press key[3] -> dropped. With q_level=2, a third legal press -> dropped.
- **Bounce:** key[3] glitching low for 3 cycles repeatedly -> no press. Held low for 20 cycles -> exactly one press.
- **Collision:** q_level=2, assert pengzhuang on the terminal-count cycle -> no step pulse; game_state=2, direction=0, q_level=0. Then any press -> game_state=0.
- **Pop+enqueue:** q_level=2 (tail=1), press key[2] timed to the pop cycle -> accepted, q_level remains 2.
